sifh_peak_reader: RTL and testbench

Read-out side of the SiFH histogram RAM. After the histogram builder finishes an acquisition, this block sweeps every pixel's bins through RAM port B, finds the peak bin per pixel and presents one result per pixel on a valid/ready interface. It optionally zeroes each bin through port A right after reading it, so the RAM is clean for the next acquisition.

---
 rtl/sifh_peak_reader_pkg.sv | 18 +
 rtl/sifh_peak_tracker.sv | 30 +++
 rtl/sifh_peak_reader.sv | 140 ++++++++++++++
 tb/tb_sifh_peak_reader.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/sifh_peak_reader_pkg.sv
// Shared definitions for the SiFH histogram read-out: FSM state encodings and
// default geometry of one histogram RAM.
package sifh_peak_reader_pkg;

   typedef enum logic [2:0] {
      RD_IDLE,
      RD_RD,
      RD_DRAIN,
      RD_OUT,
      RD_FIN
   } rd_state_e;

   localparam int BIN_NUM_PER_HIS_DEF   = 256;
   localparam int PIXEL_NUM_PER_RAM_DEF = 4;
   localparam int NB_DEF                = 10;
   localparam int PEAK_MAX_DEF          = 16;

endpackage

// File: rtl/sifh_peak_tracker.sv
// Running max/argmax over the words of one pixel histogram; `clear` marks the
// first word of a pixel, which is loaded unconditionally.
module sifh_peak_tracker
   import sifh_peak_reader_pkg::*;
#(
   parameter int NB       = NB_DEF,
   parameter int PEAK_MAX = PEAK_MAX_DEF
) (
   input  logic                clk,
   input  logic                res,
   input  logic                clear,
   input  logic                valid,
   input  logic [NB-1:0]       bin,
   input  logic [PEAK_MAX-1:0] count,
   output logic [NB-1:0]       max_bin,
   output logic [PEAK_MAX-1:0] max_count
);

   // Strict compare keeps the lowest bin on ties.
   always_ff @(posedge clk) begin
      if (res) begin
         max_bin   <= '0;
         max_count <= '0;
      end else if (valid && (clear || count > max_count)) begin
         max_bin   <= bin;
         max_count <= count;
      end
   end

endmodule

// File: rtl/sifh_peak_reader.sv
// Sweeps every pixel histogram through RAM port B, reports the peak bin per pixel
// on a valid/ready port. Define SIFH_CLEAR_EN to zero each bin via port A after reading.
module sifh_peak_reader
   import sifh_peak_reader_pkg::*;
#(
   parameter int NB                = NB_DEF,
   parameter int PEAK_MAX          = PEAK_MAX_DEF,
   parameter int BIN_NUM_PER_HIS   = BIN_NUM_PER_HIS_DEF,
   parameter int PIXEL_NUM_PER_RAM = PIXEL_NUM_PER_RAM_DEF,
   parameter int NPIX              = 2
) (
   input  logic                clk,
   input  logic                res,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic [NB-1:0]       raddr,
   output logic                readFlag,
   input  logic [PEAK_MAX-1:0] counts,
   output logic [NB-1:0]       waddr,
   output logic                writeFlag,
   output logic                wEnable,
   output logic [PEAK_MAX-1:0] newCounts,
   output logic                peak_valid,
   input  logic                peak_ready,
   output logic [NPIX-1:0]     peak_pixel,
   output logic [NB-1:0]       peak_bin,
   output logic [PEAK_MAX-1:0] peak_count
);

   localparam logic [NB-1:0]   LAST_BIN = NB'(BIN_NUM_PER_HIS - 1);
   localparam logic [NPIX-1:0] LAST_PIX = NPIX'(PIXEL_NUM_PER_RAM - 1);
   localparam logic [NB-1:0]   ONE_ADDR = NB'(1);
   localparam logic [NPIX-1:0] ONE_PIX  = NPIX'(1);

   rd_state_e       state;
   logic [NB-1:0]   bin;
   logic [NB-1:0]   bin_d;
   logic            rd_d;

   // NOTE: every register here updates with <= so all of them see the pre-edge values.
   always_ff @(posedge clk) begin
      if (res) begin
         state      <= RD_IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         raddr      <= '0;
         readFlag   <= 1'b0;
         peak_valid <= 1'b0;
         peak_pixel <= '0;
         bin        <= '0;
         bin_d      <= '0;
         rd_d       <= 1'b0;
      end else begin
         rd_d  <= readFlag;
         bin_d <= bin;
         done  <= 1'b0;
         case (state)
            RD_IDLE: begin
               if (start) begin
                  state      <= RD_RD;
                  busy       <= 1'b1;
                  readFlag   <= 1'b1;
                  raddr      <= '0;
                  bin        <= '0;
                  peak_pixel <= '0;
               end
            end
            RD_RD: begin
               // raddr is the flat pixel*BIN+bin address kept as a running count.
               raddr <= raddr + ONE_ADDR;
               if (bin == LAST_BIN) begin
                  readFlag <= 1'b0;
                  bin      <= '0;
                  state    <= RD_DRAIN;
               end else begin
                  bin <= bin + ONE_ADDR;
               end
            end
            RD_DRAIN: begin
               peak_valid <= 1'b1;
               state      <= RD_OUT;
            end
            RD_OUT: begin
               if (peak_ready) begin
                  peak_valid <= 1'b0;
                  if (peak_pixel == LAST_PIX) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= RD_FIN;
                  end else begin
                     peak_pixel <= peak_pixel + ONE_PIX;
                     readFlag   <= 1'b1;
                     state      <= RD_RD;
                  end
               end
            end
            RD_FIN:  state <= RD_IDLE;
            default: state <= RD_IDLE;
         endcase
      end
   end

   // The tracker sees each word the cycle it returns; bin_d is its bin index.
   sifh_peak_tracker #(
      .NB       (NB),
      .PEAK_MAX (PEAK_MAX)
   ) u_tracker (
      .clk       (clk),
      .res       (res),
      .clear     (rd_d && (bin_d == '0)),
      .valid     (rd_d),
      .bin       (bin_d),
      .count     (counts),
      .max_bin   (peak_bin),
      .max_count (peak_count)
   );

   assign newCounts = '0;

`ifdef SIFH_CLEAR_EN
   // Writing the word read last cycle never collides with this cycle's read.
   always_ff @(posedge clk) begin
      if (res) begin
         waddr     <= '0;
         writeFlag <= 1'b0;
         wEnable   <= 1'b0;
      end else begin
         waddr     <= raddr;
         writeFlag <= readFlag;
         wEnable   <= readFlag;
      end
   end
`else
   assign waddr     = '0;
   assign writeFlag = 1'b0;
   assign wEnable   = 1'b0;
`endif

endmodule

// File: tb/tb_sifh_peak_reader.sv
// Directed bench for sifh_peak_reader with a behavioural dual-port RAM;
// expectations follow SIFH_CLEAR_EN when it is defined.
module tb_sifh_peak_reader;

   localparam int NB = 10, PM = 16, BIN = 256, PIX = 4, NPIX = 2;
   localparam int WORDS = BIN * PIX;

   logic            clk = 1'b0;
   logic            res = 1'b1;
   logic            start = 1'b0;
   logic            peak_ready = 1'b1;
   logic            busy, done, readFlag, writeFlag, wEnable, peak_valid;
   logic [NB-1:0]   raddr, waddr, peak_bin;
   logic [PM-1:0]   counts = '0;
   logic [PM-1:0]   newCounts, peak_count;
   logic [NPIX-1:0] peak_pixel;

   logic [PM-1:0] mem [0:WORDS-1];
   logic          load = 1'b0;
   int            cyc = 0;
   int            nreads = 0;
   int            checks = 0;
   int            failures = 0;
   int            s_cyc, r0, bad;

   always #5 clk = ~clk;

   sifh_peak_reader #(
      .NB(NB), .PEAK_MAX(PM), .BIN_NUM_PER_HIS(BIN), .PIXEL_NUM_PER_RAM(PIX), .NPIX(NPIX)
   ) dut (
      .clk(clk), .res(res), .start(start), .busy(busy), .done(done),
      .raddr(raddr), .readFlag(readFlag), .counts(counts),
      .waddr(waddr), .writeFlag(writeFlag), .wEnable(wEnable), .newCounts(newCounts),
      .peak_valid(peak_valid), .peak_ready(peak_ready), .peak_pixel(peak_pixel),
      .peak_bin(peak_bin), .peak_count(peak_count)
   );

   function automatic logic [PM-1:0] exp_word(input int a);
      int p, b;
      p = a / BIN;
      b = a % BIN;
      case (p)
         0:       return (b == 37) ? 16'd500 : 16'd3;
         1:       return (b == 10 || b == 200) ? 16'd99 : PM'(b % 50);
         2:       return 16'd0;
         default: return (b == 255) ? 16'hFFFF : PM'(b % 8);
      endcase
   endfunction

   // RAM model: port B registered read, port A write, bench preload on `load`.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (readFlag) begin
         counts <= mem[raddr];
         nreads <= nreads + 1;
      end
      if (writeFlag && wEnable) mem[waddr] <= newCounts;
      if (load) for (int i = 0; i < WORDS; i++) mem[i] <= exp_word(i);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic preload();
      @(negedge clk); load = 1'b1;
      @(negedge clk); load = 1'b0;
   endtask

   task automatic do_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      s_cyc = cyc;
   endtask

   task automatic get_result(input int pix, input int eb, input int ec, input int hold);
      int n;
      int rb;
      peak_ready = (hold == 0);
      n = 0;
      @(negedge clk);
      while (!peak_valid && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("valid_p%0d", pix), peak_valid, 1);
      check($sformatf("pixel_p%0d", pix), peak_pixel, pix);
      check($sformatf("bin_p%0d", pix), peak_bin, eb);
      check($sformatf("count_p%0d", pix), peak_count, ec);
      if (hold > 0) begin
         rb = nreads;
         repeat (hold) begin
            @(negedge clk);
            check("stall_hold", {peak_valid, peak_pixel, peak_bin, peak_count},
                  {1'b1, NPIX'(pix), NB'(eb), PM'(ec)});
         end
         check("stall_no_reads", nreads - rb, 0);
         peak_ready = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int exp_lat);
      int n;
      n = 0;
      @(negedge clk);
      while (!done && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("done_seen", done, 1);
      check("sweep_latency", cyc - s_cyc + 1, exp_lat);
      @(negedge clk);
      check("done_pulse_end", {done, busy}, 2'b00);
   endtask

   task automatic check_dump(input string tag);
      logic [PM-1:0] e;
      bad = 0;
      for (int i = 0; i < WORDS; i++) begin
`ifdef SIFH_CLEAR_EN
         e = '0;
`else
         e = exp_word(i);
`endif
         if (mem[i] !== e) bad++;
      end
      check(tag, bad, 0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ctl"}, {busy, done, readFlag, writeFlag, wEnable, peak_valid}, 0);
      check({tag, "_addr"}, {raddr, waddr}, 0);
      check({tag, "_res"}, {peak_pixel, peak_bin, peak_count, newCounts}, 0);
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      res = 1'b0;
      preload();

      // Sweep 1: ready high except a 20-cycle stall on pixel 1
      r0 = nreads;
      do_start();
      check("first_read", {busy, readFlag, raddr}, {1'b1, 1'b1, NB'(0)});
      get_result(0, 37, 500, 0);
      get_result(1, 10, 99, 20);
      get_result(2, 0, 0, 0);
      get_result(3, 255, 16'hFFFF, 0);
      wait_done(PIX * (BIN + 2) + 1 + 20);
      check("read_total", nreads - r0, WORDS);
      repeat (2) @(negedge clk);
      check_dump("dump_sweep1");

      // Reset in the middle of pixel 2's read phase
      preload();
      do_start();
      get_result(0, 37, 500, 0);
      get_result(1, 10, 99, 0);
      repeat (100) @(negedge clk);
      check("mid_p2", {readFlag, raddr >= NB'(512) && raddr < NB'(768)}, 2'b11);
      res = 1'b1;
      @(negedge clk);
      check_all_zero("mid_reset");
      res = 1'b0;
      repeat (2) @(negedge clk);
      check("p3_kept", mem[3 * BIN + 255], 16'hFFFF);
`ifdef SIFH_CLEAR_EN
      check("p1_cleared", mem[BIN + 10], 0);
`else
      check("p1_kept", mem[BIN + 10], 99);
`endif

      // Full sweep after reset with ready tied high
      preload();
      r0 = nreads;
      do_start();
      get_result(0, 37, 500, 0);
      get_result(1, 10, 99, 0);
      get_result(2, 0, 0, 0);
      get_result(3, 255, 16'hFFFF, 0);
      wait_done(PIX * (BIN + 2) + 1);
      check("read_total2", nreads - r0, WORDS);
      repeat (2) @(negedge clk);
      check_dump("dump_sweep2");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
